// File: rtl/mcu_spi_bridge.sv
// ---------------------------------------------------------------------------
// mcu_spi_bridge
// Bridges an MCU SPI master (mode 1: SCK idles low, data launched on the
// rising edge, sampled on the falling edge) into the core clock domain.
// The first word of each chip-select frame is a target id. Every later word
// is a payload word, strobed to the addressed target. The MCU reads back
// mcu_status during the id word and the core reply word during each
// following word.
//
// Ports
//   clk          core clock, rising edge
//   reset        synchronous active-high reset
//   spi_io_ss    MCU chip select, active low (asynchronous)
//   spi_io_clk   SPI clock (asynchronous)
//   spi_io_din   MOSI (asynchronous)
//   spi_io_dout  MISO
//   mcu_strobe   one-hot payload strobe, bit k -> target k+1
//   mcu_start    high with the strobe of payload word 0
//   mcu_dout     received payload word
//   mcu_index    payload word index, saturating at 255
//   mcu_din      reply word, shifted out during the next word
//   mcu_status   status word, shifted out during the id word
// ---------------------------------------------------------------------------
module mcu_spi_bridge #(
  parameter int NUM_TARGETS = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spi_io_ss,
  input  logic                   spi_io_clk,
  input  logic                   spi_io_din,
  output logic                   spi_io_dout,
  output logic [NUM_TARGETS-1:0] mcu_strobe,
  output logic                   mcu_start,
  output logic [DATA_W-1:0]      mcu_dout,
  output logic [7:0]             mcu_index,
  input  logic [DATA_W-1:0]      mcu_din,
  input  logic [DATA_W-1:0]      mcu_status
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MAX_ID   = DATA_W'(NUM_TARGETS);

  typedef enum logic [1:0] {WAIT_HI, IDLE, TARGET, PAYLOAD} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] ss_pipe_reg, sck_pipe_reg, din_pipe_reg;
  logic                   sck_prev_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [DATA_W-1:0]      rx_reg;
  logic [DATA_W-1:0]      tx_reg;
  logic [DATA_W-1:0]      id_reg;
  logic [7:0]             pay_cnt_reg;
  logic                   done_d_reg;
  logic                   dout_reg;
  logic [NUM_TARGETS-1:0] strobe_reg;
  logic                   start_reg;
  logic [DATA_W-1:0]      mcu_dout_reg;
  logic [7:0]             mcu_index_reg;

  logic                   ss_s, sck_s, din_s;
  logic                   active, fall_det, rise_det, word_done, id_valid;
  logic [DATA_W-1:0]      rx_word;
  logic [NUM_TARGETS-1:0] strobe_next;

  assign ss_s  = ss_pipe_reg[SYNC_STAGES-1];
  assign sck_s = sck_pipe_reg[SYNC_STAGES-1];
  assign din_s = din_pipe_reg[SYNC_STAGES-1];

  // Shifting is gated on a live chip select so that a deasserting ss
  // never completes a partial word.
  assign active    = ((state_reg == TARGET) || (state_reg == PAYLOAD)) && !ss_s;
  assign fall_det  = active && sck_prev_reg && !sck_s;
  assign rise_det  = active && !sck_prev_reg && sck_s;
  assign word_done = fall_det && (bit_cnt_reg == LAST_BIT);
  assign rx_word   = {rx_reg[DATA_W-2:0], din_s};
  assign id_valid  = (id_reg != '0) && (id_reg <= MAX_ID);

  generate
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_strobe
      assign strobe_next[gi] = id_valid && (id_reg == DATA_W'(gi + 1));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_HI: if (ss_s) state_next = IDLE;
      IDLE:    if (!ss_s) state_next = TARGET;
      TARGET: begin
        if (ss_s)           state_next = IDLE;
        else if (word_done) state_next = PAYLOAD;
      end
      PAYLOAD: if (ss_s) state_next = IDLE;
      default: state_next = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= WAIT_HI;
      ss_pipe_reg   <= '0;
      sck_pipe_reg  <= '0;
      din_pipe_reg  <= '0;
      sck_prev_reg  <= 1'b0;
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      id_reg        <= '0;
      pay_cnt_reg   <= '0;
      done_d_reg    <= 1'b0;
      dout_reg      <= 1'b0;
      strobe_reg    <= '0;
      start_reg     <= 1'b0;
      mcu_dout_reg  <= '0;
      mcu_index_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ss_pipe_reg  <= {ss_pipe_reg[SYNC_STAGES-2:0], spi_io_ss};
      sck_pipe_reg <= {sck_pipe_reg[SYNC_STAGES-2:0], spi_io_clk};
      din_pipe_reg <= {din_pipe_reg[SYNC_STAGES-2:0], spi_io_din};
      sck_prev_reg <= sck_s;
      strobe_reg   <= '0;
      start_reg    <= 1'b0;
      done_d_reg   <= word_done;

      // Outside a live frame: drop any partial word and the frame context.
      if (!active) begin
        bit_cnt_reg <= '0;
        rx_reg      <= '0;
        id_reg      <= '0;
        pay_cnt_reg <= '0;
        dout_reg    <= 1'b0;
      end

      // Transmit path: status on frame entry, reply word one clk after each
      // completed word (id_reg is already updated by then), else shift.
      if ((state_reg == IDLE) && !ss_s) begin
        tx_reg <= mcu_status;
      end else if (done_d_reg && active) begin
        tx_reg <= id_valid ? mcu_din : '0;
      end else if (rise_det) begin
        dout_reg <= tx_reg[DATA_W-1];
        tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
      end

      if (fall_det) begin
        rx_reg      <= rx_word;
        bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + 1'b1;
      end

      if (word_done) begin
        if (state_reg == TARGET) begin
          id_reg <= rx_word;
        end else begin
          mcu_dout_reg  <= rx_word;
          mcu_index_reg <= pay_cnt_reg;
          strobe_reg    <= strobe_next;
          start_reg     <= id_valid && (pay_cnt_reg == 8'd0);
          if (pay_cnt_reg != 8'hFF) pay_cnt_reg <= pay_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign spi_io_dout = dout_reg;
  assign mcu_strobe  = strobe_reg;
  assign mcu_start   = start_reg;
  assign mcu_dout    = mcu_dout_reg;
  assign mcu_index   = mcu_index_reg;

endmodule

// File: doc/mcu_spi_bridge.md
MCU_SPI_BRIDGE -- requirements
Module: mcu_spi_bridge

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 4: number of payload targets, ids 1..NUM_TARGETS.
REQ-002 SHALL have parameter DATA_W, default 8: SPI word width in bits, legal range 8..16.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for spi_io_ss, spi_io_clk and spi_io_din, minimum 2.
REQ-004 SHALL have port clk, input, 1: the single core clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port spi_io_ss, input, 1: MCU chip select, active low, asynchronous to clk.
REQ-007 SHALL have port spi_io_clk, input, 1: SPI clock in mode 1, asynchronous to clk.
REQ-008 SHALL have port spi_io_din, input, 1: MOSI.
REQ-009 SHALL have port spi_io_dout, output, 1: MISO.
REQ-010 SHALL have port mcu_strobe, output, NUM_TARGETS: one-hot payload-word strobe; bit k serves target k+1.
REQ-011 SHALL have port mcu_start, output, 1: marks the first payload word of a transaction.
REQ-012 SHALL have port mcu_dout, output, DATA_W: received payload word.
REQ-013 SHALL have port mcu_index, output, 8: payload word index within the transaction, starting at 0.
REQ-014 SHALL have port mcu_din, input, DATA_W: core reply word, returned to the MCU during the next word.
REQ-015 SHALL have port mcu_status, input, DATA_W: status word, returned to the MCU during the target-id word.

Function
REQ-016 SHALL pass spi_io_ss, spi_io_clk and spi_io_din through SYNC_STAGES flops each, and detect edges from the synchronised spi_io_clk versus its previous sample.
REQ-017 SHALL implement an FSM with these states and transitions:
- WAIT_HI --(sync ss high)--> IDLE
- IDLE --(sync ss low)--> TARGET
- TARGET --(DATA_W bits received)--> PAYLOAD
- TARGET or PAYLOAD --(sync ss high)--> IDLE
REQ-018 SHALL, in TARGET and PAYLOAD, shift sync din into the receive register MSB-first on each detected falling edge of the synchronised spi_io_clk; a bit counter SHALL wrap at DATA_W.
REQ-019 SHALL latch the completed TARGET word as the target id and SHALL NOT strobe for it.
REQ-020 SHALL, for each completed PAYLOAD word, register mcu_dout and pulse mcu_strobe[id-1] for exactly one clk, one cycle after the falling-edge detect cycle, when 1<=id<=NUM_TARGETS.
REQ-021 SHALL keep mcu_strobe all-zero for id 0 or id >NUM_TARGETS; mcu_dout and mcu_index SHALL still update.
REQ-022 SHALL assert mcu_start in the same cycle as the strobe of payload word 0 only.
REQ-023 SHALL hold mcu_index valid with mcu_dout; it increments after each payload word and saturates at 255.
REQ-024 SHALL load the transmit register with mcu_status on entry to TARGET.
REQ-025 SHALL load the transmit register with mcu_din one clk after each word completes; for an invalid id it SHALL load zero.
REQ-026 SHALL, on each detected rising edge of sync spi_io_clk in TARGET/PAYLOAD, drive spi_io_dout from the transmit-register MSB and then shift it left.
REQ-027 SHALL drive spi_io_dout to 0 in IDLE and WAIT_HI.
REQ-028 SHALL discard a partial word when ss deasserts, with no strobe, and SHALL clear the bit counter, id and index.
REQ-029 SHALL operate correctly when every SCK half-period is at least SYNC_STAGES+3 clk periods.

Reset
REQ-030 SHALL, on reset, enter WAIT_HI and clear all counters, id and the shift registers.
REQ-031 SHALL, on reset, drive spi_io_dout, mcu_strobe, mcu_start, mcu_dout and mcu_index to 0.
REQ-032 SHALL, on reset mid-transaction, ignore the remainder of that transfer until ss is seen high.

Verification
REQ-033 SHALL cover: defaults; MCU sends 0x02,0xA5,0x3C -> mcu_strobe=0b0010 twice; mcu_dout 0xA5 then 0x3C; mcu_index 0 then 1; mcu_start with first strobe only.
REQ-034 SHALL cover: mcu_status=0x81 and mcu_din=0x5A held; MCU clocks 0x01,0x00 -> MISO reads 0x81 then 0x5A.
REQ-035 SHALL cover: target 0x07 with NUM_TARGETS=4, 3 payload words -> no strobes; mcu_index reaches 2; MISO reads status then 0x00,0x00.
REQ-036 SHALL cover: ss raised after 5 bits of payload word 1 -> exactly one strobe; next transaction starts with mcu_index=0.
REQ-037 SHALL cover: reset asserted mid-payload with ss held low -> outputs 0 and no strobes until ss toggles high then low; then 0x01,0x11 gives one strobe with mcu_dout 0x11.
REQ-038 SHALL cover: DATA_W=16, NUM_TARGETS=8, target 0x0008 then 0xBEEF -> mcu_strobe=0x80, mcu_dout 0xBEEF; 300 payload words -> mcu_index saturates at 255.
